// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
// Module   : pong_ball_engine
// Brief    : Frame-stepped ball/paddle physics and scoring for VGA pong.
//            Optional PONG_SPIN_EN: paddle hit position steers vertical dir.
// Revision : 1.0 - initial release
// ============================================================================
module pong_ball_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 16,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 64,
    parameter int PAD_L_X      = 16,
    parameter int PAD_R_X      = 616,
    parameter int STEP_MAX     = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               serve,
    input  logic [9:0]         pad_l_y,
    input  logic [9:0]         pad_r_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic               ball_visible,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               point_l,
    output logic               point_r,
    output logic [1:0]         state
);
    localparam int SPD_W = (STEP_MAX < 2) ? 1 : $clog2(STEP_MAX + 1);
    localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]         c_cx       = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]         c_cy       = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0]         c_rx_stop  = 10'(PAD_R_X - BALL_SIZE);
    localparam logic signed [11:0] c_zero     = 12'sd0;
    localparam logic signed [11:0] c_lx       = 12'(PAD_L_X + PAD_W);
    localparam logic signed [11:0] c_rx       = 12'(PAD_R_X);
    localparam logic signed [11:0] c_ball_s   = 12'(BALL_SIZE);
    localparam logic signed [11:0] c_ymax     = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] c_xmax     = 12'(H_RES - BALL_SIZE);
    localparam logic [11:0]        c_ball_u   = 12'(BALL_SIZE);
    localparam logic [11:0]        c_pad_h    = 12'(PAD_H);
    localparam logic [SPD_W-1:0]   c_spd_max  = SPD_W'(STEP_MAX);
    localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] c_score_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t             r_state, w_state;
    logic [9:0]         r_x, r_y, w_x, w_y;
    logic               r_dx, r_dy, w_dx, w_dy;        // dx 1 = right, dy 1 = down
    logic [SPD_W-1:0]   r_spd, w_spd, w_spd_up;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [SCORE_W-1:0] r_score_l, r_score_r, w_score_l, w_score_r;
    logic [SCORE_W-1:0] w_score_l_inc, w_score_r_inc;
    logic               r_point_l, r_point_r, w_point_l, w_point_r;

    logic signed [11:0] w_xs, w_ys, w_sp, w_nx, w_ny;
    logic [11:0]        w_y12, w_pl12, w_pr12;
    logic               w_ovl_l, w_ovl_r, w_hit_l, w_hit_r, w_miss_l, w_miss_r;

    assign w_xs   = $signed({2'b00, r_x});
    assign w_ys   = $signed({2'b00, r_y});
    assign w_sp   = $signed({{(12 - SPD_W){1'b0}}, r_spd});
    assign w_nx   = r_dx ? (w_xs + w_sp) : (w_xs - w_sp);
    assign w_ny   = r_dy ? (w_ys + w_sp) : (w_ys - w_sp);
    assign w_y12  = {2'b00, r_y};
    assign w_pl12 = {2'b00, pad_l_y};
    assign w_pr12 = {2'b00, pad_r_y};

    // Overlap uses the pre-step y against the paddle span
    assign w_ovl_l  = ((w_y12 + c_ball_u) > w_pl12) && (w_y12 < (w_pl12 + c_pad_h));
    assign w_ovl_r  = ((w_y12 + c_ball_u) > w_pr12) && (w_y12 < (w_pr12 + c_pad_h));
    assign w_hit_l  = !r_dx && (w_xs >= c_lx) && (w_nx <= c_lx) && w_ovl_l;
    assign w_hit_r  = r_dx && ((w_xs + c_ball_s) <= c_rx) && ((w_nx + c_ball_s) >= c_rx) && w_ovl_r;
    assign w_miss_l = !r_dx && (w_nx < c_zero);
    assign w_miss_r = r_dx && (w_nx > c_xmax);

    assign w_spd_up      = (r_spd >= c_spd_max) ? r_spd : (r_spd + SPD_W'(1));
    assign w_score_l_inc = r_score_l + SCORE_W'(1);
    assign w_score_r_inc = r_score_r + SCORE_W'(1);

`ifdef PONG_SPIN_EN
    localparam logic signed [11:0] c_third     = 12'(PAD_H / 3);
    localparam logic signed [11:0] c_two_third = 12'((2 * PAD_H) / 3);
    logic signed [11:0] w_rel_l, w_rel_r;
    assign w_rel_l = $signed(w_y12 + 12'(BALL_SIZE / 2) - w_pl12);
    assign w_rel_r = $signed(w_y12 + 12'(BALL_SIZE / 2) - w_pr12);
`endif

    always_comb begin
        w_state   = r_state;
        w_x       = r_x;
        w_y       = r_y;
        w_dx      = r_dx;
        w_dy      = r_dy;
        w_spd     = r_spd;
        w_cnt     = r_cnt;
        w_score_l = r_score_l;
        w_score_r = r_score_r;
        w_point_l = 1'b0;
        w_point_r = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (serve) begin
                    w_state = ST_SERVE;
                    w_cnt   = '0;
                end
            end
            ST_SERVE: begin
                w_x = c_cx;
                w_y = c_cy;
                if (frame_tick) begin
                    if (r_cnt == c_cnt_last) begin
                        w_state = ST_PLAY;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (r_dy && (w_ny >= c_ymax)) begin
                        w_y  = c_ymax[9:0];
                        w_dy = 1'b0;
                    end else if (!r_dy && (w_ny <= c_zero)) begin
                        w_y  = '0;
                        w_dy = 1'b1;
                    end else begin
                        w_y = w_ny[9:0];
                    end

                    if (w_hit_l) begin
                        w_x   = c_lx[9:0];
                        w_dx  = 1'b1;
                        w_spd = w_spd_up;
`ifdef PONG_SPIN_EN
                        if (w_rel_l < c_third)           w_dy = 1'b0;
                        else if (w_rel_l >= c_two_third) w_dy = 1'b1;
`endif
                    end else if (w_hit_r) begin
                        w_x   = c_rx_stop;
                        w_dx  = 1'b0;
                        w_spd = w_spd_up;
`ifdef PONG_SPIN_EN
                        if (w_rel_r < c_third)           w_dy = 1'b0;
                        else if (w_rel_r >= c_two_third) w_dy = 1'b1;
`endif
                    end else if (w_miss_l || w_miss_r) begin
                        // Re-centre and re-serve; the vertical direction carries over
                        w_x   = c_cx;
                        w_y   = c_cy;
                        w_spd = SPD_W'(1);
                        w_cnt = '0;
                        if (w_miss_l) begin
                            w_point_r = 1'b1;
                            w_score_r = w_score_r_inc;
                            w_dx      = 1'b0;
                            w_state   = (w_score_r_inc == c_score_max) ? ST_OVER : ST_SERVE;
                        end else begin
                            w_point_l = 1'b1;
                            w_score_l = w_score_l_inc;
                            w_dx      = 1'b1;
                            w_state   = (w_score_l_inc == c_score_max) ? ST_OVER : ST_SERVE;
                        end
                    end else begin
                        w_x = w_nx[9:0];
                    end
                end
            end
            ST_OVER: begin
                if (serve) begin
                    w_score_l = '0;
                    w_score_r = '0;
                    w_spd     = SPD_W'(1);
                    w_cnt     = '0;
                    w_state   = ST_SERVE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_x       <= c_cx;
            r_y       <= c_cy;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_spd     <= SPD_W'(1);
            r_cnt     <= '0;
            r_score_l <= '0;
            r_score_r <= '0;
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_x       <= w_x;
            r_y       <= w_y;
            r_dx      <= w_dx;
            r_dy      <= w_dy;
            r_spd     <= w_spd;
            r_cnt     <= w_cnt;
            r_score_l <= w_score_l;
            r_score_r <= w_score_r;
            r_point_l <= w_point_l;
            r_point_r <= w_point_r;
        end
    end

    assign ball_x       = r_x;
    assign ball_y       = r_y;
    assign ball_visible = (r_state == ST_SERVE) || (r_state == ST_PLAY);
    assign score_l      = r_score_l;
    assign score_r      = r_score_r;
    assign point_l      = r_point_l;
    assign point_r      = r_point_r;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_ball_engine
// Brief    : Directed game-play bench for pong_ball_engine with a game-level
//            reference model checked every cycle plus literal pin points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_ball_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] pad_l_y = '0;
    logic [9:0] pad_r_y = '0;
    logic [9:0] ball_x, ball_y;
    logic       ball_visible;
    logic [3:0] score_l, score_r;
    logic       point_l, point_r;
    logic [1:0] state;

    pong_ball_engine dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve(serve),
        .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .ball_x(ball_x), .ball_y(ball_y), .ball_visible(ball_visible),
        .score_l(score_l), .score_r(score_r),
        .point_l(point_l), .point_r(point_r), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Game model: integer position, +1/-1 directions, state 0..3 as on the port
    int m_x, m_y, m_dx, m_dy, m_spd, m_cnt, m_sl, m_sr, m_st;
    bit m_pl, m_pr;
    bit m_valid = 1'b0;
    bit track_l, track_r;

    always @(posedge clk) begin : model
        int nx, ny, ty, tdy, oy;
        bit hl, hr;
        m_pl = 1'b0;
        m_pr = 1'b0;
        if (!rst_n) begin
            m_st = 0; m_x = 312; m_y = 232; m_dx = 1; m_dy = 1; m_spd = 1;
            m_cnt = 0; m_sl = 0; m_sr = 0; m_valid = 1'b1;
        end else if (m_st == 0) begin
            if (serve) begin m_st = 1; m_cnt = 0; end
        end else if (m_st == 1) begin
            if (frame_tick) begin
                m_cnt++;
                if (m_cnt == 60) begin m_st = 2; m_cnt = 0; end
            end
        end else if (m_st == 3) begin
            if (serve) begin m_sl = 0; m_sr = 0; m_spd = 1; m_cnt = 0; m_st = 1; end
        end else if (frame_tick) begin
            nx = m_x + m_dx * m_spd;
            ny = m_y + m_dy * m_spd;
            oy = m_y;
            if (m_dy > 0 && ny >= 464)      begin ty = 464; tdy = -1; end
            else if (m_dy < 0 && ny <= 0)   begin ty = 0;   tdy = 1;  end
            else                            begin ty = ny;  tdy = m_dy; end
            hl = (m_dx < 0) && (m_x >= 24) && (nx <= 24) &&
                 (oy + 16 > int'(pad_l_y)) && (oy < int'(pad_l_y) + 64);
            hr = (m_dx > 0) && (m_x + 16 <= 616) && (nx + 16 >= 616) &&
                 (oy + 16 > int'(pad_r_y)) && (oy < int'(pad_r_y) + 64);
            m_y  = ty;
            m_dy = tdy;
            if (hl || hr) begin
                m_x  = hl ? 24 : 600;
                m_dx = hl ? 1 : -1;
                if (m_spd < 4) m_spd++;
`ifdef PONG_SPIN_EN
                begin
                    int r;
                    r = oy + 8 - (hl ? int'(pad_l_y) : int'(pad_r_y));
                    if (r < 21)       m_dy = -1;
                    else if (r >= 42) m_dy = 1;
                end
`endif
            end else if (nx < 0 || nx > 624) begin
                if (nx < 0) begin m_sr++; m_pr = 1'b1; m_dx = -1; end
                else        begin m_sl++; m_pl = 1'b1; m_dx = 1;  end
                m_x = 312; m_y = 232; m_spd = 1; m_cnt = 0;
                m_st = (m_sl == 15 || m_sr == 15) ? 3 : 1;
            end else begin
                m_x = nx;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || state !== 2'(m_st) ||
                score_l !== 4'(m_sl) || score_r !== 4'(m_sr) ||
                point_l !== m_pl || point_r !== m_pr ||
                ball_visible !== (m_st == 1 || m_st == 2)) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got x=%0d y=%0d st=%0d sc=%0d/%0d pt=%b%b vis=%b required x=%0d y=%0d st=%0d sc=%0d/%0d pt=%b%b",
                         $time, ball_x, ball_y, state, score_l, score_r, point_l, point_r,
                         ball_visible, m_x, m_y, m_st, m_sl, m_sr, m_pl, m_pr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        pad_l_y    = track_l ? 10'(m_y) : 10'd1000;
        pad_r_y    = track_r ? 10'(m_y) : 10'd1000;
        frame_tick = 1'b1;
        step_clk();
        frame_tick = 1'b0;
        step_clk();
        step_clk();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"},     32'(ball_x), 312);
        chk({tag, "_y"},     32'(ball_y), 232);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_sl"},    32'(score_l), 0);
        chk({tag, "_sr"},    32'(score_r), 0);
        chk({tag, "_vis"},   32'(ball_visible), 0);
    endtask

    initial begin
        int  prev;
        bit  found;
        bit  first;
        track_l = 1'b1;
        track_r = 1'b1;
        rst_n   = 1'b0;
        step_clk();
        step_clk();
        rst_n = 1'b1;
        chk_reset("reset");

        // Serve request coincident with a frame tick: that tick is not counted
        serve = 1'b1; frame_tick = 1'b1;
        step_clk();
        serve = 1'b0; frame_tick = 1'b0;
        step_clk();
        chk("serve_state", 32'(state), 1);
        repeat (59) do_tick();
        chk("serve_59", 32'(state), 1);
        do_tick();
        chk("play_state", 32'(state), 2);
        chk("play_vis", 32'(ball_visible), 1);
        do_tick();
        chk("step1_x", 32'(ball_x), 313);
        chk("step1_y", 32'(ball_y), 233);

        repeat (231) do_tick();
        chk("wall_y", 32'(ball_y), 464);
        chk("wall_x", 32'(ball_x), 544);
        do_tick();
        chk("wall_back_y", 32'(ball_y), 463);
        repeat (54) do_tick();
        do_tick();
        chk("rhit_x", 32'(ball_x), 600);
        chk("rhit_y", 32'(ball_y), 408);
        do_tick();
        chk("speed2_x", 32'(ball_x), 598);
        chk("speed2_y", 32'(ball_y), 406);

        // Keep rallying so speed saturates, then confirm 4 px per frame
        repeat (711) do_tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            prev = int'(ball_x);
            do_tick();
            if (prev > 24 && prev < 600 && int'(ball_x) > 24 && int'(ball_x) < 600) begin
                chk("speed_sat", 32'((int'(ball_x) > prev) ? int'(ball_x) - prev : prev - int'(ball_x)), 4);
                found = 1'b1;
            end
        end
        if (!found) chk("speed_sat_window", 32'(0), 1);

        // Right player absent: left scores
        track_r = 1'b0;
        for (int i = 0; i < 3000 && score_l !== 4'd1; i++) do_tick();
        chk("pl_score", 32'(score_l), 1);
        chk("pl_state", 32'(state), 1);
        chk("pl_x", 32'(ball_x), 312);

        // Left player absent until the game ends
        track_l = 1'b0;
        track_r = 1'b1;
        first   = 1'b1;
        for (int i = 0; i < 15000 && state !== 2'd3; i++) begin
            do_tick();
            if (first && score_r === 4'd1) begin
                chk("miss_x", 32'(ball_x), 312);
                chk("miss_y", 32'(ball_y), 232);
                chk("miss_state", 32'(state), 1);
                first = 1'b0;
            end
        end
        chk("over_sr", 32'(score_r), 15);
        chk("over_sl", 32'(score_l), 1);
        chk("over_state", 32'(state), 3);
        chk("over_vis", 32'(ball_visible), 0);

        serve = 1'b1;
        step_clk();
        serve = 1'b0;
        chk("restart_state", 32'(state), 1);
        chk("restart_sl", 32'(score_l), 0);
        chk("restart_sr", 32'(score_r), 0);
        repeat (60) do_tick();
        chk("restart_play", 32'(state), 2);
        repeat (3) do_tick();

        // Reset asserted in the same cycle as a frame tick during play
        rst_n = 1'b0; frame_tick = 1'b1;
        step_clk();
        step_clk();
        rst_n = 1'b1; frame_tick = 1'b0;
        chk_reset("midreset");
        step_clk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
